preadder_sched: RTL and testbench
=================================

Name: preadder_sched

Overview:
- Two-requester scheduler for the BN254 Fp pre-adder, which has fixed latency and no stall.
- Arbitrates operand beats from two requesters, with round-robin priority and chain locking, and drives registered X/Y/mode1/mode2 into the pre-adder.
- Enforces the back-to-back rule for modes that use the pre-adder's previous-cycle operand (mode1=01 uses dly_x; mode2=10 uses dly_y).
- Delays requester id and tag so they align with Z0/Z1.

Parameters:
- W, bit_width (PARAMS_BN254_d0): Fp operand width.
- TAG_W, 4: width of the requester tag carried with each beat.
- PA_LAT, 4: cycles from pa_* registered outputs to Z0/Z1 valid (adder LATENCY 3 + output reg 1).

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- rq_valid  in  2  per-requester beat valid.
- rq_ready  out  2  per-requester accept; combinational, one-hot or zero.
- rq0_x, rq1_x  in  W  X operand.
- rq0_y, rq1_y  in  W  Y operand.
- rq0_mode1, rq1_mode1  in  2  pre-adder mode1 (00 pass X, 01 dly_x+X, 10 X+Y).
- rq0_mode2, rq1_mode2  in  2  pre-adder mode2 (00 pass Y, 01 X−Y, 10 Y+dly_y).
- rq0_chain, rq1_chain  in  1  next beat of this requester must issue in the very next cycle.
- rq0_tag, rq1_tag  in  TAG_W  opaque tag.
- pa_x, pa_y  out  W  to pre-adder X, Y.
- pa_mode1, pa_mode2  out  2  to pre-adder mode1, mode2.
- res_valid  out  1  Z0/Z1 hold a scheduled result this cycle.
- res_id  out  1  requester of that result.
- res_tag  out  TAG_W  tag of that result.
- inflight  out  3  number of beats issued and not yet retired.
- err_dep  out  1  sticky: dependent mode issued without a same-requester predecessor.
- err_chain  out  1  sticky: a locked requester failed to present a beat.

Behaviour:
- Reset (rstn=0, async): pa_x=pa_y=0, pa_mode1=pa_mode2=00, rq_ready=00, res_valid=0, res_id=0, res_tag=0, inflight=0, err_*=0, lock=0, rr pointer=0.
  - All delay-line valids clear.
  - Reset mid-operation discards every in-flight beat; no res_valid after release until new issues.
- Accept: beat k is accepted in cycle t when rq_valid[k] & rq_ready[k].
  - At t+1 pa_* carry the beat's x, y, mode1, mode2.
  - At t+1+PA_LAT, res_valid=1 with res_id=k and res_tag=tag.
  - Results cannot be back-pressured.
- Idle cycles (no accept): next cycle pa_mode1=pa_mode2=00, pa_x/pa_y hold their values, and no result is generated.
- State machine:
  - ARB (lock=0):
    - grant the only valid requester;
    - if both are valid, grant the one indicated by the rr pointer;
    - after a grant, the rr pointer points to the other requester.
  - LOCK(k): entered when the granted beat has chain=1; lock=1, owner=k.
    - Only k may be granted, and rq_ready of the other requester = 0.
    - A beat with chain=0 returns to ARB in the next cycle.
    - If rq_valid[k]=0 while in LOCK: set err_chain, grant nothing this cycle, return to ARB.
- Dependency check, at accept:
  - Condition: mode1=01 or mode2=10.
  - Legal only if the previous cycle accepted a beat from the same requester.
  - Otherwise set err_dep; the beat is still issued unchanged.
  - Mode 11 is treated as 00 and passed through unchanged.
- inflight: +1 on accept, −1 on res_valid. Both in the same cycle → unchanged. Maximum value is PA_LAT+1.
- Delay line: a shift register of {valid, id, tag}, depth PA_LAT+1, loaded at accept.
- Simultaneous events:
  - Accept and lock exit in the same cycle: the accepted beat's chain bit decides.
  - Both requesters valid in LOCK: only the owner is granted; the rr pointer is still updated after the owner's grant.
- err_dep and err_chain clear only on reset.

Test Plan:
- Single beat: rq0 x=5, y=3, mode1=10, mode2=01, tag=7 accepted at t → pa_x=5, pa_mode1=10 at t+1; res_valid=1, res_id=0, res_tag=7 at t+5 (PA_LAT=4); inflight 1 from t+1 to t+5, then 0.
- Round-robin: both requesters valid every cycle, chain=0 → grants alternate 0,1,0,1; res_id sequence 0,1,0,1; inflight saturates at 5, steady.
- Chain lock: rq0 sends 3 beats chain=1,1,0 (second and third mode1=01) while rq1 is valid throughout → rq0 granted 3 consecutive cycles; rq1 granted on the 4th; err_dep stays 0.
- Dependency violation: rq1 beat with mode2=10 accepted immediately after an rq0 beat → err_dep=1 next cycle and stays 1; the result still appears with res_id=1.
- Chain break: rq0 chain=1 beat, then rq_valid[0]=0 for one cycle → err_chain=1; rq1 is granted in the following cycle.
- Reset mid-flight: issue 3 beats, assert rstn=0 asynchronously between clock edges → all outputs 0 immediately; after release, no res_valid appears for ≥ PA_LAT+2 cycles.

Source files
------------

// File: rtl/preadder_sched.sv
// preadder_sched: two-requester round-robin scheduler with chain lock for the BN254 Fp pre-adder
//   clk, rstn                  clock, async active-low reset
//   rq_valid/rq_ready          per-requester handshake (ready is combinational, one-hot or zero)
//   rqN_x/y/mode1/mode2/chain/tag  beat fields of requester N
//   pa_x/pa_y/pa_mode1/pa_mode2    registered operands/modes to the pre-adder
//   res_valid/res_id/res_tag   result marker aligned with Z0/Z1
//   inflight                   beats issued and not yet retired
//   err_dep/err_chain          sticky protocol errors
module preadder_sched #(
  parameter int W = 254,
  parameter int TAG_W = 4,
  parameter int PA_LAT = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [1:0]       rq_valid,
  output logic [1:0]       rq_ready,
  input  logic [W-1:0]     rq0_x,
  input  logic [W-1:0]     rq1_x,
  input  logic [W-1:0]     rq0_y,
  input  logic [W-1:0]     rq1_y,
  input  logic [1:0]       rq0_mode1,
  input  logic [1:0]       rq1_mode1,
  input  logic [1:0]       rq0_mode2,
  input  logic [1:0]       rq1_mode2,
  input  logic             rq0_chain,
  input  logic             rq1_chain,
  input  logic [TAG_W-1:0] rq0_tag,
  input  logic [TAG_W-1:0] rq1_tag,
  output logic [W-1:0]     pa_x,
  output logic [W-1:0]     pa_y,
  output logic [1:0]       pa_mode1,
  output logic [1:0]       pa_mode2,
  output logic             res_valid,
  output logic             res_id,
  output logic [TAG_W-1:0] res_tag,
  output logic [2:0]       inflight,
  output logic             err_dep,
  output logic             err_chain
);
  localparam int D = PA_LAT + 1;
  typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;
  state_t state_q, state_d;
  logic owner_q, owner_d, rr_q, rr_d, prev_acc_q, prev_acc_d, prev_id_q, prev_id_d;
  logic [W-1:0] pa_x_q, pa_x_d, pa_y_q, pa_y_d;
  logic [1:0] pa_mode1_q, pa_mode1_d, pa_mode2_q, pa_mode2_d;
  logic [D-1:0] dv_q, dv_d, di_q, di_d;
  logic [D*TAG_W-1:0] dt_q, dt_d;
  logic [2:0] inflight_q, inflight_d;
  logic err_dep_q, err_dep_d, err_chain_q, err_chain_d;
  logic acc, gid, dep, g_chain;
  logic [1:0] g_m1, g_m2;
  assign res_valid = dv_q[D-1];
  assign res_id = di_q[D-1];
  assign res_tag = dt_q[D*TAG_W-1 -: TAG_W];
  assign pa_x = pa_x_q;
  assign pa_y = pa_y_q;
  assign pa_mode1 = pa_mode1_q;
  assign pa_mode2 = pa_mode2_q;
  assign inflight = inflight_q;
  assign err_dep = err_dep_q;
  assign err_chain = err_chain_q;
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    rq_ready = 2'b00;
    err_chain_d = err_chain_q;
    if (state_q == LOCK) begin
      gid = owner_q;
      if (rq_valid[owner_q]) rq_ready[owner_q] = 1'b1;
      else begin
        err_chain_d = 1'b1;
        state_d = ARB;
      end
    end else begin
      gid = (rq_valid == 2'b10) ? 1'b1 : (rq_valid == 2'b01) ? 1'b0 : rr_q;
      rq_ready[gid] = |rq_valid;
    end
    acc = |(rq_valid & rq_ready);
    g_m1 = gid ? rq1_mode1 : rq0_mode1;
    g_m2 = gid ? rq1_mode2 : rq0_mode2;
    g_chain = gid ? rq1_chain : rq0_chain;
    // dly_x / dly_y only hold this requester's data if it issued last cycle
    dep = (g_m1 == 2'b01) || (g_m2 == 2'b10);
    err_dep_d = err_dep_q | (acc & dep & ~(prev_acc_q & (prev_id_q == gid)));
    if (acc) begin
      state_d = g_chain ? LOCK : ARB;
      owner_d = gid;
      rr_d = ~gid;
    end
    prev_acc_d = acc;
    prev_id_d = gid;
    pa_x_d = acc ? (gid ? rq1_x : rq0_x) : pa_x_q;
    pa_y_d = acc ? (gid ? rq1_y : rq0_y) : pa_y_q;
    pa_mode1_d = acc ? g_m1 : 2'b00;
    pa_mode2_d = acc ? g_m2 : 2'b00;
    dv_d = {dv_q[D-2:0], acc};
    di_d = {di_q[D-2:0], gid};
    dt_d = {dt_q[(D-1)*TAG_W-1:0], gid ? rq1_tag : rq0_tag};
    inflight_d = inflight_q + 3'(acc) - 3'(res_valid);
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ARB;
      owner_q <= 1'b0;
      rr_q <= 1'b0;
      prev_acc_q <= 1'b0;
      prev_id_q <= 1'b0;
      pa_x_q <= '0;
      pa_y_q <= '0;
      pa_mode1_q <= 2'b00;
      pa_mode2_q <= 2'b00;
      dv_q <= '0;
      di_q <= '0;
      dt_q <= '0;
      inflight_q <= 3'd0;
      err_dep_q <= 1'b0;
      err_chain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      prev_acc_q <= prev_acc_d;
      prev_id_q <= prev_id_d;
      pa_x_q <= pa_x_d;
      pa_y_q <= pa_y_d;
      pa_mode1_q <= pa_mode1_d;
      pa_mode2_q <= pa_mode2_d;
      dv_q <= dv_d;
      di_q <= di_d;
      dt_q <= dt_d;
      inflight_q <= inflight_d;
      err_dep_q <= err_dep_d;
      err_chain_q <= err_chain_d;
    end
  end
endmodule

// File: tb/tb_preadder_sched.sv
// tb_preadder_sched: randomized and directed check of preadder_sched against a behavioural model
module tb_preadder_sched;
  localparam int W = 16, TW = 4, PL = 4;
  logic clk = 1'b0, rstn = 1'b0;
  logic [1:0] rq_valid = 2'b00, rq_ready;
  logic [W-1:0] x[2], y[2];
  logic [1:0] m1[2], m2[2];
  logic ch[2];
  logic [TW-1:0] tg[2];
  logic [W-1:0] pa_x, pa_y;
  logic [1:0] pa_mode1, pa_mode2;
  logic res_valid, res_id, err_dep, err_chain;
  logic [TW-1:0] res_tag;
  logic [2:0] inflight;
  preadder_sched #(.W(W), .TAG_W(TW), .PA_LAT(PL)) dut (
    .clk(clk), .rstn(rstn), .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq0_x(x[0]), .rq1_x(x[1]), .rq0_y(y[0]), .rq1_y(y[1]),
    .rq0_mode1(m1[0]), .rq1_mode1(m1[1]), .rq0_mode2(m2[0]), .rq1_mode2(m2[1]),
    .rq0_chain(ch[0]), .rq1_chain(ch[1]), .rq0_tag(tg[0]), .rq1_tag(tg[1]),
    .pa_x(pa_x), .pa_y(pa_y), .pa_mode1(pa_mode1), .pa_mode2(pa_mode2),
    .res_valid(res_valid), .res_id(res_id), .res_tag(res_tag), .inflight(inflight),
    .err_dep(err_dep), .err_chain(err_chain));
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int owner = -1, rr = 0;
  logic [W-1:0] e_x = '0, e_y = '0;
  logic [1:0] e_m1 = 2'b00, e_m2 = 2'b00;
  bit e_ed = 0, e_ec = 0;
  bit hv[64];
  int hid[64], htag[64];
  logic [1:0] last_rdy;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic bit hv_at(int c);
    return (c >= 0) ? hv[c % 64] : 1'b0;
  endfunction
  task automatic model_reset();
    owner = -1; rr = 0; e_x = '0; e_y = '0; e_m1 = 2'b00; e_m2 = 2'b00; e_ed = 0; e_ec = 0;
    for (int i = 0; i < 64; i++) hv[i] = 0;
  endtask
  task automatic set(int k, bit v, int xv, int yv, int a, int b, bit c, int t);
    rq_valid[k] = v; x[k] = W'(xv); y[k] = W'(yv); m1[k] = 2'(a); m2[k] = 2'(b); ch[k] = c; tg[k] = TW'(t);
  endtask
  // Entered at posedge+1 with inputs driven; compares at the falling edge, then advances the model.
  task automatic step();
    int g, r, cnt;
    bit brk, dp;
    #4;
    g = -1; brk = 0; cnt = 0;
    if (owner >= 0) begin
      if (rq_valid[owner]) g = owner; else brk = 1;
    end else if (rq_valid == 2'b11) g = rr;
    else if (rq_valid[0]) g = 0;
    else if (rq_valid[1]) g = 1;
    r = cyc - 1 - PL;
    for (int a = cyc - 1 - PL; a <= cyc - 1; a++) cnt += int'(hv_at(a));
    last_rdy = rq_ready;
    chk("rq_ready", rq_ready, (g < 0) ? 2'b00 : 2'(1 << g));
    chk("pa_x", pa_x, e_x);
    chk("pa_y", pa_y, e_y);
    chk("pa_mode1", pa_mode1, e_m1);
    chk("pa_mode2", pa_mode2, e_m2);
    chk("res_valid", res_valid, hv_at(r));
    if (hv_at(r)) begin
      chk("res_id", res_id, hid[r % 64]);
      chk("res_tag", res_tag, htag[r % 64]);
    end
    chk("inflight", inflight, cnt);
    chk("err_dep", err_dep, e_ed);
    chk("err_chain", err_chain, e_ec);
    if (brk) begin e_ec = 1; owner = -1; end
    if (g >= 0) begin
      dp = (m1[g] == 2'b01) || (m2[g] == 2'b10);
      if (dp && !(hv_at(cyc - 1) && hid[(cyc - 1) % 64] == g)) e_ed = 1;
      e_x = x[g]; e_y = y[g]; e_m1 = m1[g]; e_m2 = m2[g];
      owner = ch[g] ? g : -1;
      rr = 1 - g;
      hv[cyc % 64] = 1; hid[cyc % 64] = g; htag[cyc % 64] = int'(tg[g]);
    end else begin
      e_m1 = 2'b00; e_m2 = 2'b00; hv[cyc % 64] = 0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int n);
    rq_valid = 2'b00;
    repeat (n) step();
  endtask
  task automatic do_reset();
    rq_valid = 2'b00;
    #2 rstn = 1'b0;
    #1;
    chk("rst_pa_x", pa_x, 0);
    chk("rst_pa_mode1", pa_mode1, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", {err_dep, err_chain}, 0);
    chk("rst_ready", rq_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    model_reset();
  endtask
  initial begin
    for (int k = 0; k < 2; k++) set(k, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("init_pa_y", pa_y, 0);
    chk("init_res_tag", res_tag, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    // single beat
    set(0, 1, 5, 3, 2, 1, 0, 7);
    step();
    chk("sb_pa_x", pa_x, 5);
    chk("sb_pa_mode1", pa_mode1, 2);
    chk("sb_inflight", inflight, 1);
    idle(3);
    step();
    chk("sb_res", {res_valid, res_id, res_tag}, {1'b1, 1'b0, 4'd7});
    chk("sb_inflight5", inflight, 1);
    step();
    chk("sb_done", {res_valid, inflight}, 0);
    // round robin, both valid
    for (int i = 0; i < 12; i++) begin
      set(0, 1, i, i + 1, 2, 0, 0, i);
      set(1, 1, 100 + i, i, 0, 1, 0, 8 + (i % 8));
      step();
      if (i > 0) chk("rr_alt", last_rdy[0], i % 2);
    end
    chk("rr_inflight_sat", inflight, 5);
    idle(7);
    // chain lock, rq1 valid throughout
    set(1, 1, 9, 9, 0, 0, 0, 1);
    step();
    set(0, 1, 1, 1, 2, 0, 1, 2);
    step();
    chk("lk_g0", last_rdy, 2'b01);
    set(0, 1, 2, 2, 1, 0, 1, 3);
    step();
    chk("lk_g1", last_rdy, 2'b01);
    set(0, 1, 3, 3, 1, 0, 0, 4);
    step();
    chk("lk_g2", last_rdy, 2'b01);
    rq_valid[0] = 1'b0;
    step();
    chk("lk_g3", last_rdy, 2'b10);
    chk("lk_err_dep", err_dep, 0);
    idle(7);
    // dependency violation
    set(0, 1, 4, 4, 0, 0, 0, 5);
    step();
    rq_valid[0] = 1'b0;
    set(1, 1, 6, 6, 0, 2, 0, 6);
    step();
    chk("dep_err", err_dep, 1);
    rq_valid = 2'b00;
    repeat (4) step();
    chk("dep_res", {res_valid, res_id, res_tag}, {1'b1, 1'b1, 4'd6});
    idle(3);
    chk("dep_sticky", err_dep, 1);
    // chain break
    set(0, 1, 7, 7, 0, 0, 1, 8);
    set(1, 1, 8, 8, 0, 0, 0, 9);
    step();
    chk("cb_g0", last_rdy, 2'b01);
    rq_valid[0] = 1'b0;
    step();
    chk("cb_none", last_rdy, 2'b00);
    chk("cb_err", err_chain, 1);
    step();
    chk("cb_g1", last_rdy, 2'b10);
    idle(2);
    // reset mid-flight
    for (int i = 0; i < 3; i++) begin
      set(0, 1, 20 + i, 30 + i, 2, 1, 0, i);
      step();
    end
    do_reset();
    for (int i = 0; i < PL + 3; i++) begin
      step();
      chk("rst_no_res", res_valid, 0);
    end
    // randomized traffic
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 300; i++) begin
        for (int k = 0; k < 2; k++)
          set(k, $urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, 15));
        step();
      end
      idle(3);
      do_reset();
      idle(2);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
